// File: rtl/regfile_param.sv
// Parameterised multi-read-port register file with a one-register-per-cycle
// clear sequencer and a sticky flag for discarded writes.
module regfile_param #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 0,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       PW,
  input  logic [AW-1:0]          RW,
  input  logic                   LE,
  input  logic [NREAD*AW-1:0]    RA,
  input  logic                   CLR,
  output logic [NREAD*WIDTH-1:0] PR,
  output logic                   BUSY,
  output logic                   WDROP
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t         state, state_nxt;
  logic [AW-1:0]  cnt, cnt_nxt;
  logic           wdrop_nxt;
  logic           busy;
  logic           wr_zero;
  logic           wr_en;
  logic           drop;
  logic [WIDTH-1:0] mem [DEPTH];

  // Reset low counts as busy so reads are masked even before the first edge.
  assign busy    = !rst_n || (state == CLEAR);
  assign wr_zero = (ZERO_REG != 0) && (RW == '0);
  assign wr_en   = LE && !busy && !CLR && !wr_zero;
  assign drop    = LE && (busy || CLR) && !wr_zero;
  assign BUSY    = busy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt   <= '0;
      WDROP <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      WDROP <= wdrop_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wdrop_nxt = WDROP;
    case (state)
      IDLE: begin
        if (CLR) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        if (CLR) begin
          cnt_nxt = '0;
        end else if (cnt == LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + AW'(1);
        end
      end
      default: begin
        state_nxt = CLEAR;
        cnt_nxt   = '0;
      end
    endcase
    // A clear request only wipes the flag when it did not itself drop a write.
    if (CLR && !LE) begin
      wdrop_nxt = 1'b0;
    end else if (drop) begin
      wdrop_nxt = 1'b1;
    end
  end

  // Register contents carry no reset; the clear sequence zeroes them instead.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == CLEAR && !CLR) begin
        mem[cnt] <= '0;
      end else if (wr_en) begin
        mem[RW] <= PW;
      end
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0]    sel;
    logic [WIDTH-1:0] rd;

    assign sel = RA[i*AW +: AW];

    always_comb begin
      rd = mem[sel];
      if (busy) begin
        rd = '0;
      end else if ((ZERO_REG != 0) && (sel == '0)) begin
        rd = '0;
      end else if ((BYPASS != 0) && wr_en && (sel == RW)) begin
        rd = PW;
      end
    end

    assign PR[i*WIDTH +: WIDTH] = rd;
  end

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench for regfile_param: three instances (default, bypass, 16x8 with four read ports).
module tb_regfile_param;

  localparam int K_PR    = 0;
  localparam int K_BUSY  = 1;
  localparam int K_WDROP = 2;

  typedef struct {
    int          dut;
    int          kind;
    int          idx;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t q[$];
  int   checks = 0;
  int   fails  = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_a [3];
  logic        le_a    [3];
  logic        clr_a   [3];
  logic [31:0] pw_a    [3];
  logic [4:0]  rw_a    [3];
  logic [4:0]  ra_a    [3][4];

  logic [63:0] pr0, pr1, pr2;
  logic        busy0, busy1, busy2;
  logic        wdrop0, wdrop1, wdrop2;

  regfile_param u_def (
    .clk(clk), .rst_n(rst_n_a[0]), .PW(pw_a[0]), .RW(rw_a[0]), .LE(le_a[0]),
    .RA({ra_a[0][1], ra_a[0][0]}), .CLR(clr_a[0]), .PR(pr0), .BUSY(busy0), .WDROP(wdrop0)
  );

  regfile_param #(.BYPASS(1)) u_byp (
    .clk(clk), .rst_n(rst_n_a[1]), .PW(pw_a[1]), .RW(rw_a[1]), .LE(le_a[1]),
    .RA({ra_a[1][1], ra_a[1][0]}), .CLR(clr_a[1]), .PR(pr1), .BUSY(busy1), .WDROP(wdrop1)
  );

  regfile_param #(.WIDTH(16), .DEPTH(8), .NREAD(4)) u_small (
    .clk(clk), .rst_n(rst_n_a[2]), .PW(pw_a[2][15:0]), .RW(rw_a[2][2:0]), .LE(le_a[2]),
    .RA({ra_a[2][3][2:0], ra_a[2][2][2:0], ra_a[2][1][2:0], ra_a[2][0][2:0]}),
    .CLR(clr_a[2]), .PR(pr2), .BUSY(busy2), .WDROP(wdrop2)
  );

  function automatic logic [31:0] actual(chk_t c);
    logic [31:0] v;
    v = 32'hx;
    case (c.kind)
      K_PR: begin
        if (c.dut == 0)      v = pr0[c.idx*32 +: 32];
        else if (c.dut == 1) v = pr1[c.idx*32 +: 32];
        else                 v = {16'h0, pr2[c.idx*16 +: 16]};
      end
      K_BUSY:  v = {31'h0, (c.dut == 0) ? busy0  : (c.dut == 1) ? busy1  : busy2};
      K_WDROP: v = {31'h0, (c.dut == 0) ? wdrop0 : (c.dut == 1) ? wdrop1 : wdrop2};
      default: v = 32'hx;
    endcase
    return v;
  endfunction

  // Monitor: drains every pending expectation on the falling edge.
  initial begin
    chk_t        c;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        c = q.pop_front();
        a = actual(c);
        checks++;
        if (a !== c.exp) begin
          fails++;
          $display("FAIL %s: dut%0d idx%0d got 0x%08h expected 0x%08h at %0t",
                   c.name, c.dut, c.idx, a, c.exp, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d checks, %0d failures", checks, fails);
    $fatal(1, "timeout");
  end

  task automatic expect_val(input int dut, input int kind, input int idx,
                            input logic [31:0] exp, input string name);
    chk_t c;
    c.dut = dut; c.kind = kind; c.idx = idx; c.exp = exp; c.name = name;
    q.push_back(c);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic busy_run(input int dut, input int n, input string name);
    for (int k = 0; k < n; k++) begin
      expect_val(dut, K_BUSY, 0, 32'd1, name);
      cyc();
    end
    expect_val(dut, K_BUSY, 0, 32'd0, {name, "_end"});
  endtask

  task automatic wr(input int dut, input int r, input logic [31:0] v);
    le_a[dut] = 1'b1;
    rw_a[dut] = 5'(r);
    pw_a[dut] = v;
    cyc();
    le_a[dut] = 1'b0;
  endtask

  task automatic release_reset(input int dut, input int depth);
    rst_n_a[dut] = 1'b1;
    le_a[dut]    = 1'b0;
    busy_run(dut, depth, "reset_clear_busy");
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst_n_a[d] = 1'b0;
      le_a[d]    = 1'b0;
      clr_a[d]   = 1'b0;
      pw_a[d]    = '0;
      rw_a[d]    = '0;
      for (int p = 0; p < 4; p++) ra_a[d][p] = '0;
    end

    // ---------------- default instance ----------------
    le_a[0] = 1'b1; rw_a[0] = 5'd3; pw_a[0] = 32'hCAFE0003; ra_a[0][0] = 5'd3;
    expect_val(0, K_BUSY, 0, 32'd1, "busy_in_reset");
    expect_val(0, K_PR,   0, 32'd0, "pr_in_reset");
    cyc();
    cyc();
    expect_val(0, K_WDROP, 0, 32'd0, "wdrop_after_reset");
    expect_val(0, K_PR,    0, 32'd0, "pr_in_reset_2");
    cyc();
    release_reset(0, 32);
    cyc();

    for (int r = 0; r < 32; r++) begin
      ra_a[0][0] = 5'(r);
      ra_a[0][1] = 5'(31 - r);
      expect_val(0, K_PR, 0, 32'd0, "post_clear_zero");
      expect_val(0, K_PR, 1, 32'd0, "post_clear_zero");
      cyc();
    end

    wr(0, 5, 32'hDEADBEEF);
    wr(0, 31, 32'h12345678);
    ra_a[0][0] = 5'd5; ra_a[0][1] = 5'd31;
    expect_val(0, K_PR, 0, 32'hDEADBEEF, "read_r5");
    expect_val(0, K_PR, 1, 32'h12345678, "read_r31");
    cyc();
    ra_a[0][0] = 5'd31; ra_a[0][1] = 5'd5;
    expect_val(0, K_PR, 0, 32'h12345678, "read_swap_p0");
    expect_val(0, K_PR, 1, 32'hDEADBEEF, "read_swap_p1");

    wr(0, 0, 32'hFFFFFFFF);
    ra_a[0][0] = 5'd0;
    expect_val(0, K_PR,    0, 32'd0, "r0_reads_zero");
    expect_val(0, K_WDROP, 0, 32'd0, "r0_write_no_drop");
    cyc();

    ra_a[0][0] = 5'd5;
    le_a[0] = 1'b1; rw_a[0] = 5'd5; pw_a[0] = 32'h11112222;
    expect_val(0, K_PR, 0, 32'hDEADBEEF, "nobypass_old");
    cyc();
    le_a[0] = 1'b0;
    expect_val(0, K_PR, 0, 32'h11112222, "nobypass_new");
    cyc();

    wr(0, 3, 32'h0BADF00D);
    clr_a[0] = 1'b1; le_a[0] = 1'b1; rw_a[0] = 5'd3; pw_a[0] = 32'h33333333;
    cyc();
    clr_a[0] = 1'b0; le_a[0] = 1'b0;
    ra_a[0][0] = 5'd5; ra_a[0][1] = 5'd31;
    expect_val(0, K_WDROP, 0, 32'd1, "clr_drop_sets_wdrop");
    for (int k = 0; k < 32; k++) begin
      expect_val(0, K_PR, 0, 32'd0, "busy_masks_p0");
      expect_val(0, K_PR, 1, 32'd0, "busy_masks_p1");
      expect_val(0, K_BUSY, 0, 32'd1, "clr_busy");
      cyc();
    end
    ra_a[0][0] = 5'd3;
    expect_val(0, K_BUSY,  0, 32'd0, "clr_busy_end");
    expect_val(0, K_WDROP, 0, 32'd1, "wdrop_sticky");
    expect_val(0, K_PR,    0, 32'd0, "r3_cleared");
    expect_val(0, K_PR,    1, 32'd0, "r31_cleared");
    cyc();

    clr_a[0] = 1'b1;
    cyc();
    clr_a[0] = 1'b0;
    expect_val(0, K_WDROP, 0, 32'd0, "clr_no_le_clears_wdrop");
    busy_run(0, 32, "clr2_busy");
    cyc();

    clr_a[0] = 1'b1;
    cyc();
    clr_a[0] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      expect_val(0, K_BUSY, 0, 32'd1, "restart_busy_a");
      if (k == 9) clr_a[0] = 1'b1;
      cyc();
    end
    clr_a[0] = 1'b0;
    busy_run(0, 32, "restart_busy_b");
    cyc();

    clr_a[0] = 1'b1;
    cyc();
    clr_a[0] = 1'b0;
    le_a[0] = 1'b1; rw_a[0] = 5'd4; pw_a[0] = 32'h44444444;
    cyc();
    le_a[0] = 1'b0;
    expect_val(0, K_WDROP, 0, 32'd1, "busy_write_drops");
    cyc();
    cyc();
    rst_n_a[0] = 1'b0; le_a[0] = 1'b1; rw_a[0] = 5'd6; clr_a[0] = 1'b1;
    expect_val(0, K_BUSY, 0, 32'd1, "midclear_reset_busy");
    cyc();
    clr_a[0] = 1'b0;
    expect_val(0, K_WDROP, 0, 32'd0, "reset_clears_wdrop");
    cyc();
    expect_val(0, K_WDROP, 0, 32'd0, "reset_write_no_drop");
    release_reset(0, 32);
    cyc();

    // ---------------- bypass instance ----------------
    release_reset(1, 32);
    cyc();
    wr(1, 7, 32'h11111111);
    ra_a[1][0] = 5'd7; ra_a[1][1] = 5'd7;
    le_a[1] = 1'b1; rw_a[1] = 5'd7; pw_a[1] = 32'hA5A5A5A5;
    expect_val(1, K_PR, 0, 32'hA5A5A5A5, "bypass_p0");
    expect_val(1, K_PR, 1, 32'hA5A5A5A5, "bypass_p1");
    cyc();
    le_a[1] = 1'b0;
    expect_val(1, K_PR, 0, 32'hA5A5A5A5, "bypass_after");
    cyc();
    ra_a[1][0] = 5'd0;
    le_a[1] = 1'b1; rw_a[1] = 5'd0; pw_a[1] = 32'hFFFFFFFF;
    expect_val(1, K_PR, 0, 32'd0, "bypass_r0_zero");
    expect_val(1, K_PR, 1, 32'hA5A5A5A5, "bypass_r0_other");
    cyc();
    le_a[1] = 1'b0;
    ra_a[1][0] = 5'd7;
    clr_a[1] = 1'b1; le_a[1] = 1'b1; rw_a[1] = 5'd7; pw_a[1] = 32'h00005555;
    expect_val(1, K_PR, 0, 32'hA5A5A5A5, "no_bypass_with_clr");
    cyc();
    clr_a[1] = 1'b0; le_a[1] = 1'b0;
    expect_val(1, K_WDROP, 0, 32'd1, "bypass_clr_drop");
    busy_run(1, 32, "bypass_clr_busy");
    cyc();

    // ---------------- 16x8, four read ports ----------------
    release_reset(2, 8);
    cyc();
    for (int r = 1; r < 8; r++) wr(2, r, 32'(r));
    for (int s = 0; s < 8; s++) begin
      ra_a[2][0] = 5'(s);
      ra_a[2][1] = 5'((s + 1) % 8);
      ra_a[2][2] = 5'((s + 3) % 8);
      ra_a[2][3] = 5'((s + 5) % 8);
      expect_val(2, K_PR, 0, 32'(s),           "small_p0");
      expect_val(2, K_PR, 1, 32'((s + 1) % 8), "small_p1");
      expect_val(2, K_PR, 2, 32'((s + 3) % 8), "small_p2");
      expect_val(2, K_PR, 3, 32'((s + 5) % 8), "small_p3");
      cyc();
    end

    cyc();
    for (int k = 0; k < 10 && q.size() > 0; k++) cyc();
    if (q.size() > 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
